// File: rtl/rr_grant_dispatcher.sv
// Consumer side of the round-robin arbiter. Each accepted grant pops one word from the
// granted FWFT source queue and forwards it to the downstream link FIFO.
module rr_grant_dispatcher #(
  parameter int DATA_W = 10,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [1:0]        out_id,
  input  logic [3:0]        empty,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  input  logic              dn_full,
  output logic [3:0]        pop,
  output logic              push,
  output logic [DATA_W-1:0] data_out,
  output logic              arb_stall,
  output logic              err_empty,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  grant_cnt2,
  output logic [CNT_W-1:0]  grant_cnt3
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] POP  = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [1:0]                 id_q, id_d;
  logic [DATA_W-1:0]          data_q, data_d;
  logic                       err_q, err_d;
  logic [3:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]          head_word;

  always_comb begin
    case (id_q)
      2'd0:    head_word = data0;
      2'd1:    head_word = data1;
      2'd2:    head_word = data2;
      default: head_word = data3;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    id_d    = id_q;
    data_d  = data_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid && !dn_full) begin
          if (empty[out_id]) begin
            err_d = 1'b1;
          end else begin
            id_d          = out_id;
            cnt_d[out_id] = cnt_q[out_id] + CNT_W'(1);
            state_d       = POP;
          end
        end
      end
      POP: begin
        // The FWFT head is valid in the pop cycle; capture it before the queue advances.
        data_d  = head_word;
        state_d = SEND;
      end
      SEND: begin
        if (!dn_full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pop        = (state_q == POP) ? (4'b0001 << id_q) : 4'b0000;
  assign push       = (state_q == SEND) && !dn_full;
  assign arb_stall  = (state_q != IDLE) || dn_full;
  assign data_out   = data_q;
  assign err_empty  = err_q;
  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];
  assign grant_cnt2 = cnt_q[2];
  assign grant_cnt3 = cnt_q[3];

endmodule
